// File: rtl/charge_disp_pkg.sv
// Shared constants for the charge-bar 7-segment readout.
// Segment vectors are ordered {CA,CB,CC,CD,CE,CF,CG} and are active-low.
package charge_disp_pkg;

    // Segment patterns for 0..3 bars lit on one digit (bottom CD, middle CG, top CA)
    localparam logic [6:0] SEG_OFF  = 7'b111_1111;
    localparam logic [6:0] SEG_BAR0 = 7'b111_1111;
    localparam logic [6:0] SEG_BAR1 = 7'b111_0111;
    localparam logic [6:0] SEG_BAR2 = 7'b111_0110;
    localparam logic [6:0] SEG_BAR3 = 7'b011_0110;

    // Width of a level value: enough bits for 0..num_digits*3
    function automatic int level_width(input int num_digits);
        return $clog2(num_digits * 3 + 1);
    endfunction

endpackage

// File: rtl/svn_scan_timer.sv
// Digit-scan timebase: prescaler producing a one-cycle tick every SCAN_DIV
// clocks, a digit index that wraps NUM_DIGITS-1 -> 0, and a frame pulse on
// the cycle the index wraps.
module svn_scan_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 5000,
    parameter int IW         = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    output logic          tick,
    output logic          frame,
    output logic [IW-1:0] idx
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre_cnt;

    assign tick  = (pre_cnt == PW'(SCAN_DIV - 1));
    assign frame = tick && (idx == IW'(NUM_DIGITS - 1));

    // Prescaler and digit index; explicit wrap keeps non-power-of-2 digit counts correct
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/charge_meter_display.sv
// Charge-bar readout for an N-digit 7-segment bank. Quantises charge_bar into
// NUM_DIGITS*3 levels (three bars per digit), scans the digits, and blinks the
// whole bar while full. Optional peak-hold marker on DP is enabled by defining
// PEAK_HOLD_EN; without it DP stays high.
module charge_meter_display
    import charge_disp_pkg::*;
#(
    parameter int PHY_WIDTH    = 16,
    parameter int NUM_DIGITS   = 8,
    parameter int STEP         = 55,
    parameter int SCAN_DIV     = 5000,
    parameter int BLINK_FRAMES = 32,
    parameter int HOLD_FRAMES  = 64,
    localparam int MAX_LEVEL   = NUM_DIGITS * 3,
    localparam int LW          = level_width(NUM_DIGITS)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [PHY_WIDTH-1:0]  charge_bar,
    output logic                  CA,
    output logic                  CB,
    output logic                  CC,
    output logic                  CD,
    output logic                  CE,
    output logic                  CF,
    output logic                  CG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [LW-1:0]         level,
    output logic                  full
);

    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int XW  = LW + 1;
    localparam logic [LW-1:0]    MAX_L  = LW'(MAX_LEVEL);
    localparam logic [PHY_WIDTH:0] STEP_W = (PHY_WIDTH + 1)'(STEP);

    // Scan timebase
    logic          frame;
    logic [IW-1:0] idx;

    svn_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .IW         (IW)
    ) u_scan (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (),
        .frame     (frame),
        .idx       (idx)
    );

    // Level tracker: thresholds follow the level by +/-STEP so no multiplier is needed
    logic [PHY_WIDTH:0] thr_hi, thr_lo, thr_hi_nxt, thr_lo_nxt, charge_w;
    logic [LW-1:0]      level_nxt;

    assign charge_w = {1'b0, charge_bar};

    // Next level: clear has priority, then one step up or down per cycle
    always_comb begin
        level_nxt  = level;
        thr_hi_nxt = thr_hi;
        thr_lo_nxt = thr_lo;
        if (charge_bar == '0) begin
            level_nxt  = '0;
            thr_hi_nxt = STEP_W;
            thr_lo_nxt = '0;
        end else if (charge_w >= thr_hi && level != MAX_L) begin
            level_nxt  = level + 1'b1;
            thr_hi_nxt = thr_hi + STEP_W;
            thr_lo_nxt = thr_lo + STEP_W;
        end else if (charge_w < thr_lo && level != '0) begin
            level_nxt  = level - 1'b1;
            thr_hi_nxt = thr_hi - STEP_W;
            thr_lo_nxt = thr_lo - STEP_W;
        end
    end

    // Level, thresholds and full flag registered together
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level  <= '0;
            full   <= 1'b0;
            thr_hi <= STEP_W;
            thr_lo <= '0;
        end else begin
            level  <= level_nxt;
            full   <= (level_nxt == MAX_L);
            thr_hi <= thr_hi_nxt;
            thr_lo <= thr_lo_nxt;
        end
    end

    // Bar decode for the digit being scanned: clamp(level - 3*idx, 0, 3)
    logic [XW-1:0] base, diff;
    logic [6:0]    bar_seg;

    assign base = XW'(idx) + (XW'(idx) << 1);

    // Pick the bar pattern for the current digit
    always_comb begin
        bar_seg = SEG_BAR0;
        diff    = '0;
        if ({1'b0, level} > base) begin
            diff = {1'b0, level} - base;
            if (diff >= XW'(3)) begin
                bar_seg = SEG_BAR3;
            end else if (diff == XW'(2)) begin
                bar_seg = SEG_BAR2;
            end else begin
                bar_seg = SEG_BAR1;
            end
        end
    end

    // Blink: frame counter and phase run only while full; leaving full clears both
    logic           blink_phase;
    logic [BFW-1:0] blink_cnt;

    // Blink phase toggles every BLINK_FRAMES frames while the bar is full
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else if (level_nxt != MAX_L) begin
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
        end else if (full && frame) begin
            if (blink_cnt == BFW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Segment and anode registers: both load from idx in the same cycle, so no ghosting
    logic [6:0] seg_r;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_r <= SEG_OFF;
            AN    <= ~NUM_DIGITS'(1);
        end else begin
            seg_r <= blink_phase ? SEG_OFF : bar_seg;
            AN    <= ~(NUM_DIGITS'(1) << idx);
        end
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = seg_r;

`ifdef PEAK_HOLD_EN
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    // Peak level plus the digit/sub-bar position of bar #peak, kept incrementally
    logic [LW-1:0] peak;
    logic [IW-1:0] peak_dig;
    logic [1:0]    peak_sub;
    logic [HW-1:0] hold_cnt;
    logic          dp_r;

    // Peak follows rises, holds HOLD_FRAMES frames after a drop, then decays one level per frame
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            peak     <= '0;
            peak_dig <= '0;
            peak_sub <= '0;
            hold_cnt <= '0;
        end else if (level_nxt > peak) begin
            peak     <= peak + 1'b1;
            hold_cnt <= '0;
            if (peak == '0) begin
                peak_dig <= '0;
                peak_sub <= '0;
            end else if (peak_sub == 2'd2) begin
                peak_dig <= peak_dig + 1'b1;
                peak_sub <= '0;
            end else begin
                peak_sub <= peak_sub + 1'b1;
            end
        end else if (peak > level && frame) begin
            if (hold_cnt != HW'(HOLD_FRAMES)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                peak <= peak - 1'b1;
                if (peak == LW'(1)) begin
                    peak_dig <= '0;
                    peak_sub <= '0;
                end else if (peak_sub == 2'd0) begin
                    peak_dig <= peak_dig - 1'b1;
                    peak_sub <= 2'd2;
                end else begin
                    peak_sub <= peak_sub - 1'b1;
                end
            end
        end else if (peak <= level) begin
            hold_cnt <= '0;
        end
    end

    // DP marks the digit holding bar #peak while the peak sits above the live level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dp_r <= 1'b1;
        end else begin
            dp_r <= !((peak > level) && (peak_dig == idx));
        end
    end

    assign DP = dp_r;
`else
    assign DP = 1'b1;
`endif

endmodule

// File: tb/tb_charge_meter_display.sv
// Directed bench for charge_meter_display: reset values, scan rotation,
// a table of level-tracking vectors with segment checks, then hand-written
// sequences for blink timing, clear-while-blinking, async reset mid-rise and
// (when PEAK_HOLD_EN is defined) the peak marker.
module tb_charge_meter_display;

    localparam int FRAME_CYC = 32;

    // Hand-derived segment patterns {CA..CG}, active-low
    localparam logic [6:0] E_OFF = 7'b111_1111;
    localparam logic [6:0] E_B1  = 7'b111_0111;
    localparam logic [6:0] E_B2  = 7'b111_0110;
    localparam logic [6:0] E_B3  = 7'b011_0110;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic [15:0] charge_bar = '0;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic [7:0]  AN;
    logic [4:0]  level;
    logic        full;
    logic [6:0]  seg;

    int n_vec = 0;
    int n_err = 0;

    assign seg = {CA, CB, CC, CD, CE, CF, CG};

    charge_meter_display #(
        .PHY_WIDTH    (16),
        .NUM_DIGITS   (8),
        .STEP         (55),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .HOLD_FRAMES  (2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .charge_bar (charge_bar),
        .CA         (CA),
        .CB         (CB),
        .CC         (CC),
        .CD         (CD),
        .CE         (CE),
        .CF         (CF),
        .CG         (CG),
        .DP         (DP),
        .AN         (AN),
        .level      (level),
        .full       (full)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) until digit d is on the anodes, then return its segments
    task automatic seg_of_digit(input int d, output logic [6:0] s, output logic ok);
        logic [7:0] an_exp;
        an_exp = ~(8'(1) << d);
        ok = 1'b0;
        s  = E_OFF;
        @(negedge sys_clk);
        for (int k = 0; k < 2 * FRAME_CYC && !ok; k++) begin
            if (AN == an_exp) begin
                s  = seg;
                ok = 1'b1;
            end else begin
                @(negedge sys_clk);
            end
        end
    endtask

    typedef struct {
        logic [15:0] charge;
        int          cycles;
        logic [4:0]  lvl;
        logic        fl;
        int          dig;
        logic [6:0]  sg;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];

    initial begin
        logic [6:0] s;
        logic       ok;
        int         n;
        int         bad;
        int         seen;

        tbl[0]  = '{16'd54,  3, 5'd0, 1'b0,  0, E_OFF};
        tbl[1]  = '{16'd55,  1, 5'd1, 1'b0,  0, E_B1};
        tbl[2]  = '{16'd54,  1, 5'd0, 1'b0, -1, E_OFF};
        tbl[3]  = '{16'd165, 3, 5'd3, 1'b0,  0, E_B3};
        tbl[4]  = '{16'd165, 0, 5'd3, 1'b0,  1, E_OFF};
        tbl[5]  = '{16'd440, 4, 5'd7, 1'b0, -1, E_OFF};
        tbl[6]  = '{16'd440, 1, 5'd8, 1'b0,  2, E_B2};
        tbl[7]  = '{16'd440, 0, 5'd8, 1'b0,  1, E_B3};
        tbl[8]  = '{16'd100, 3, 5'd5, 1'b0, -1, E_OFF};
        tbl[9]  = '{16'd100, 4, 5'd1, 1'b0,  2, E_OFF};
        tbl[10] = '{16'd100, 0, 5'd1, 1'b0,  0, E_B1};
        tbl[11] = '{16'd110, 1, 5'd2, 1'b0,  0, E_B2};
        tbl[12] = '{16'd109, 1, 5'd1, 1'b0, -1, E_OFF};
        tbl[13] = '{16'd0,   1, 5'd0, 1'b0,  0, E_OFF};

        // Reset state
        @(negedge sys_clk);
        check("rst_an", AN, 8'hFE);
        check("rst_seg", seg, E_OFF);
        check("rst_dp", DP, 1'b1);
        check("rst_level", level, 0);
        check("rst_full", full, 1'b0);

        // Scan rotation: anode advances every 4 cycles and wraps after digit 7
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            logic [7:0] an_exp;
            @(negedge sys_clk);
            an_exp = ~(8'(1) << (((k - 1) / 4) % 8));
            check("scan_an", AN, an_exp);
        end

        // Table of level-tracking vectors
        for (int i = 0; i < NV; i++) begin
            charge_bar = tbl[i].charge;
            repeat (tbl[i].cycles) @(negedge sys_clk);
            check($sformatf("v%0d_level", i), level, tbl[i].lvl);
            check($sformatf("v%0d_full", i), full, tbl[i].fl);
`ifndef PEAK_HOLD_EN
            check($sformatf("v%0d_dp", i), DP, 1'b1);
`endif
            if (tbl[i].dig >= 0) begin
                seg_of_digit(tbl[i].dig, s, ok);
                check($sformatf("v%0d_scan_found", i), ok, 1'b1);
                check($sformatf("v%0d_seg", i), s, tbl[i].sg);
            end
        end

        // Full: saturates at 24, full rises with the level
        charge_bar = 16'hFFFF;
        repeat (23) @(negedge sys_clk);
        check("rise_level23", level, 5'd23);
        check("rise_full23", full, 1'b0);
        @(negedge sys_clk);
        check("full_level", level, 5'd24);
        check("full_flag", full, 1'b1);
        repeat (3) @(negedge sys_clk);
        check("sat_level", level, 5'd24);

        // Blink: wait for lit, then blank; blank and lit runs are 2 frames each
        n = 0;
        while (seg != E_B3 && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
        check("blink_lit_seen", seg, E_B3);
        n = 0;
        while (seg != E_OFF && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
        check("blink_dark_seen", seg, E_OFF);
        n = 0;
        while (seg == E_OFF && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
        check("blink_dark_len", n, 2 * FRAME_CYC);
        n = 0;
        while (seg == E_B3 && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
        check("blink_lit_len", n, 2 * FRAME_CYC);

        // Clear during the dark phase: level drops at once and blinking stops
        charge_bar = 16'd0;
        @(negedge sys_clk);
        check("clr_level", level, 0);
        check("clr_full", full, 1'b0);
        charge_bar = 16'd55;
        repeat (3) @(negedge sys_clk);
        bad  = 0;
        seen = 0;
        for (int k = 0; k < 160; k++) begin
            if (AN == 8'hFE) begin
                seen++;
                if (seg != E_B1) bad++;
            end
            @(negedge sys_clk);
        end
        check("noblink_seen", (seen > 0), 1'b1);
        check("noblink_bad", bad, 0);

        // Async reset in the middle of a rise
        charge_bar = 16'd0;
        @(negedge sys_clk);
        charge_bar = 16'hFFFF;
        repeat (5) @(negedge sys_clk);
        check("midrise_level", level, 5'd5);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_level", level, 0);
        check("arst_full", full, 1'b0);
        check("arst_an", AN, 8'hFE);
        check("arst_seg", seg, E_OFF);
        check("arst_dp", DP, 1'b1);
        charge_bar = 16'd0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("post_rst_level", level, 0);

`ifdef PEAK_HOLD_EN
        // Peak marker: rise to 8, fall to 1, DP shows on the peak digit then decays away
        charge_bar = 16'd440;
        repeat (8) @(negedge sys_clk);
        check("pk_level8", level, 5'd8);
        charge_bar = 16'd55;
        repeat (7) @(negedge sys_clk);
        check("pk_level1", level, 5'd1);
        bad  = 0;
        seen = 0;
        for (int k = 0; k < 12 * FRAME_CYC; k++) begin
            if (DP == 1'b0) begin
                if (AN == 8'hFB) seen++;
                else if (AN != 8'hFD && AN != 8'hFE) bad++;
            end
            @(negedge sys_clk);
        end
        check("pk_dig2_seen", (seen > 0), 1'b1);
        check("pk_bad_digit", bad, 0);
        bad = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (DP == 1'b0) bad++;
            @(negedge sys_clk);
        end
        check("pk_decayed", bad, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
